// File: rtl/sprite_fetch.sv
// Sprite tile-row fetcher: pulses the sorter, waits for it to settle, then reads
// both tile planes for each sorted slot from VRAM through a req/gnt arbiter.
module sprite_fetch #(
  parameter int SPRITES_PER_LINE = 10,
  parameter int SORT_WAIT        = 42
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        oam_start,
  input  logic        fetch_start,
  output logic        sort,
  output logic [3:0]  index,
  input  logic [10:0] spr_addr,
  output logic        vram_req,
  input  logic        vram_gnt,
  output logic [12:0] vram_addr,
  input  logic [7:0]  vram_q0,
  input  logic [7:0]  vram_q1,
  output logic [1:0]  dvalid,
  output logic [7:0]  data,
  output logic [7:0]  data1,
  output logic        busy,
  output logic        done
);

  localparam int              CW       = (SORT_WAIT > 1) ? $clog2(SORT_WAIT) : 1;
  localparam logic [CW-1:0]   CNT_LOAD = CW'(SORT_WAIT - 1);
  localparam logic [3:0]      LAST_IDX = 4'(SPRITES_PER_LINE - 1);

  typedef enum logic [3:0] {
    IDLE, SORT, SETTLE, WAIT_FETCH, REQ_LO, RD_LO, REQ_HI, RD_HI, NEXT
  } state_e;

  state_e        state_q, state_d;
  logic [3:0]    index_q, index_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pending_q, pending_d;
  logic          done_q, done_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      index_q   <= '0;
      cnt_q     <= '0;
      pending_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      index_q   <= index_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      done_q    <= done_d;
    end
  end

  // oam_start restarts from any state; a fetch_start in the same cycle is kept as pending.
  always_comb begin
    state_d   = state_q;
    index_d   = index_q;
    cnt_d     = cnt_q;
    pending_d = pending_q;
    done_d    = 1'b0;
    if (oam_start) begin
      state_d   = SORT;
      index_d   = '0;
      pending_d = fetch_start;
    end else begin
      case (state_q)
        IDLE: ;
        SORT: begin
          cnt_d     = CNT_LOAD;
          pending_d = pending_q | fetch_start;
          index_d   = '0;
          state_d   = SETTLE;
        end
        SETTLE: begin
          if (cnt_q <= CW'(1)) begin
            cnt_d = '0;
            if (pending_q || fetch_start) begin
              pending_d = 1'b0;
              state_d   = REQ_LO;
            end else begin
              state_d = WAIT_FETCH;
            end
          end else begin
            cnt_d     = cnt_q - CW'(1);
            pending_d = pending_q | fetch_start;
          end
        end
        WAIT_FETCH: begin
          if (fetch_start) begin
            index_d   = '0;
            pending_d = 1'b0;
            state_d   = REQ_LO;
          end
        end
        REQ_LO: if (vram_gnt) state_d = RD_LO;
        RD_LO:  state_d = REQ_HI;
        REQ_HI: if (vram_gnt) state_d = RD_HI;
        RD_HI:  state_d = NEXT;
        NEXT: begin
          if (index_q == LAST_IDX) begin
            done_d  = 1'b1;
            index_d = '0;
            state_d = IDLE;
          end else begin
            index_d = index_q + 4'd1;
            state_d = REQ_LO;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign sort      = (state_q == SORT);
  assign index     = index_q;
  assign vram_req  = (state_q == REQ_LO) || (state_q == REQ_HI);
  assign vram_addr = {1'b0, spr_addr, state_q == REQ_HI};
  assign dvalid    = {state_q == RD_HI, state_q == RD_LO};
  assign data      = vram_q0;
  assign data1     = vram_q1;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;

endmodule

// File: doc/sprite_fetch.md
Name: sprite_fetch

Overview:
- Requester side of the sprite-engine data interface, located in the video block.
- Pulses `sort` at the start of each OAM phase and waits for the sorter to settle.
- Then walks sprite indices 0..SPRITES_PER_LINE-1. For each index it reads the two tile-plane bytes from VRAM at the address the sprite engine presents, and returns them with per-plane `dvalid` strobes.
- Arbitrates with background fetch through a req/gnt pair.

Parameters:
SPRITES_PER_LINE, 10, number of leftmost sorted sprites fetched per line (1..16)
SORT_WAIT, 42, clk cycles between the `sort` pulse and the first allowed fetch (sorter settle time)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
oam_start  in  1  one-cycle pulse at the start of OAM scan for a line
fetch_start  in  1  one-cycle pulse at the start of pixel transfer (mode 3)
sort  out  1  one-cycle load pulse to the sprite sorter
index  out  4  sorted-slot index presented to the sprite engine
spr_addr  in  11  tile row address returned by the engine for `index` ({tile,row})
vram_req  out  1  VRAM read request, held until granted
vram_gnt  in  1  arbiter grant; a read is accepted in any cycle where req && gnt
vram_addr  out  13  byte address {1'b0, spr_addr, plane}
vram_q0  in  8  VRAM bank 0 read data, valid the cycle after the grant
vram_q1  in  8  VRAM bank 1 read data, valid the cycle after the grant
dvalid  out  2  bit0 = low-plane byte valid, bit1 = high-plane byte valid
data  out  8  bank 0 byte, driven from vram_q0
data1  out  8  bank 1 byte, driven from vram_q1
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse after the last sprite's high plane

Behaviour:
- Reset (async, reset_n=0): state=IDLE. sort=0, index=0, vram_req=0, dvalid=0, busy=0, done=0, sort-wait counter=0, pending=0.
- States: IDLE, SORT, SETTLE, WAIT_FETCH, REQ_LO, RD_LO, REQ_HI, RD_HI, NEXT.
- IDLE, on oam_start → SORT.
- SORT: sort=1 for exactly 1 cycle; counter loads SORT_WAIT-1; → SETTLE.
- SETTLE: decrement each cycle. At 0, go to REQ_LO if pending is set or fetch_start is high this cycle; otherwise go to WAIT_FETCH.
- fetch_start arriving during SORT or SETTLE sets pending. pending clears on entry to REQ_LO.
- WAIT_FETCH, on fetch_start → REQ_LO with index=0.
- REQ_LO: vram_req=1, vram_addr={0,spr_addr,1'b0}. When vram_gnt=1 → RD_LO. Stays in REQ_LO indefinitely while gnt=0.
- RD_LO: dvalid=2'b01 for this one cycle; data=vram_q0, data1=vram_q1 (combinational pass-through); → REQ_HI.
- REQ_HI: as REQ_LO but plane bit=1. RD_HI: dvalid=2'b10; → NEXT.
- NEXT: if index==SPRITES_PER_LINE-1 → done=1, index=0 → IDLE. Otherwise index+1 → REQ_LO.
- index is constant from the REQ_LO of a sprite through its RD_HI. index changes only in NEXT, SORT and reset.
- Latency with gnt tied high: 5 cycles per sprite (REQ_LO, RD_LO, REQ_HI, RD_HI, NEXT). done asserts 50 cycles after the first REQ_LO for 10 sprites.
- dvalid is never 2'b11. dvalid=0 in every non-RD state. vram_req is high only in REQ_* states.
- oam_start in any non-IDLE state aborts the current fetch: → SORT next cycle, index=0, vram_req drops, pending cleared, no done pulse.
- oam_start and fetch_start in the same cycle: oam_start wins; fetch_start latches pending in the following SORT.
- fetch_start while in a REQ_*/RD_*/NEXT state is ignored.
- Reset mid-fetch: outputs return to reset values immediately. No dvalid is issued after reset asserts.

Test Plan:
- Nominal, gnt=1: oam_start → sort high 1 cycle; fetch_start at cycle 50; spr_addr=0x123 → vram_addr 0x246 then 0x247; dvalid 01 then 10 for each of index 0..9; done 50 cycles after the first REQ_LO.
- Early fetch_start at cycle 10, during SETTLE → first REQ_LO exactly SORT_WAIT cycles after the sort pulse; no fetch_start lost.
- Arbiter stall: gnt=0 for 7 cycles during REQ_HI of index 3 → vram_req held, vram_addr stable, index=3, no dvalid until 1 cycle after gnt rises.
- Abort: oam_start during RD_LO of index 6 → next cycle sort=1, index=0, no dvalid=10 for index 6, no done.
- Async reset at index 4 REQ_LO → immediately vram_req=0, dvalid=0, busy=0; recovers on the next oam_start.
- Data passthrough: vram_q0=0xA5, vram_q1=0x3C in RD_LO → data=0xA5, data1=0x3C, dvalid=01 in the same cycle.
